// File: rtl/udma_uart_tx_arb.sv
// Round-robin packet arbiter sharing one UART TX serializer between NUM_REQ byte streams.
// Ownership is locked per packet and held until the serializer finishes the last stop bit.
module udma_uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int GAP_W   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_en_i,
  input  logic [GAP_W-1:0]       cfg_gap_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*8-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [7:0]             tx_data_o,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  input  logic                   tx_busy_i,
  output logic [NUM_REQ-1:0]     grant_o,
  output logic                   busy_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic               hold_vld_q, hold_vld_d;
  logic               hold_last_q, hold_last_d;
  logic [7:0]         hold_data_q, hold_data_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               drain_first_q, drain_first_d;

  logic               sel_valid_s;
  logic               sel_last_s;
  logic [7:0]         sel_data_s;
  logic               req_xfer_s;
  logic               tx_xfer_s;
  logic               drain_done_s;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) begin
      next_idx = '0;
    end else begin
      next_idx = idx + IDX_W'(1);
    end
  endfunction

  // First valid requester at or above ptr, wrapping; the rotated copy keeps the search constant-indexed.
  function automatic logic [IDX_W-1:0] pick_winner(input logic [NUM_REQ-1:0] v,
                                                    input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    int                   off;
    int                   sum;
    dbl = {v, v} >> ptr;
    off = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        off = k;
      end else begin
        off = off;
      end
    end
    sum = int'(ptr) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end else begin
      sum = sum;
    end
    pick_winner = IDX_W'(sum);
  endfunction

  // Mux the current owner's byte-stream signals.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = 8'h00;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (gidx_q == IDX_W'(r)) begin
        sel_valid_s = req_valid_i[r];
        sel_last_s  = req_last_i[r];
        sel_data_s  = req_data_i[8*r +: 8];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  assign req_xfer_s   = (state_q == ST_SEND) & sel_valid_s & ~hold_vld_q;
  assign tx_xfer_s    = (state_q == ST_SEND) & hold_vld_q & tx_ready_i;
  assign drain_done_s = (state_q == ST_DRAIN) & ~drain_first_q & ~tx_busy_i;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q       <= '0;
      gidx_q        <= '0;
      rr_q          <= '0;
      hold_vld_q    <= 1'b0;
      hold_last_q   <= 1'b0;
      hold_data_q   <= 8'h00;
      gap_cnt_q     <= '0;
      drain_first_q <= 1'b0;
    end else begin
      grant_q       <= grant_d;
      gidx_q        <= gidx_d;
      rr_q          <= rr_d;
      hold_vld_q    <= hold_vld_d;
      hold_last_q   <= hold_last_d;
      hold_data_q   <= hold_data_d;
      gap_cnt_q     <= gap_cnt_d;
      drain_first_q <= drain_first_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!cfg_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) state_d = ST_SEND;
          else              state_d = ST_IDLE;
        end
        ST_SEND: begin
          if (tx_xfer_s && hold_last_q) state_d = ST_DRAIN;
          else                          state_d = ST_SEND;
        end
        ST_DRAIN: begin
          if (drain_done_s) state_d = (cfg_gap_i != '0) ? ST_GAP : ST_IDLE;
          else              state_d = ST_DRAIN;
        end
        ST_GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) state_d = ST_IDLE;
          else                        state_d = ST_GAP;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values and the per-requester ready handshake.
  always_comb begin
    grant_d       = grant_q;
    gidx_d        = gidx_q;
    rr_d          = rr_q;
    hold_vld_d    = hold_vld_q;
    hold_last_d   = hold_last_q;
    hold_data_d   = hold_data_q;
    gap_cnt_d     = gap_cnt_q;
    drain_first_d = drain_first_q;
    req_ready_o   = '0;

    if (state_q == ST_SEND) begin
      req_ready_o = hold_vld_q ? '0 : onehot(gidx_q);
    end else begin
      req_ready_o = '0;
    end

    if (!cfg_en_i) begin
      // In-flight byte is dropped; the rr pointer survives the disable.
      grant_d       = '0;
      hold_vld_d    = 1'b0;
      drain_first_d = 1'b0;
      gap_cnt_d     = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_i) begin
            gidx_d  = pick_winner(req_valid_i, rr_q);
            grant_d = onehot(pick_winner(req_valid_i, rr_q));
          end else begin
            grant_d = '0;
          end
        end
        ST_SEND: begin
          if (req_xfer_s) begin
            hold_vld_d  = 1'b1;
            hold_last_d = sel_last_s;
            hold_data_d = sel_data_s;
          end else if (tx_xfer_s) begin
            hold_vld_d    = 1'b0;
            drain_first_d = hold_last_q;
          end else begin
            hold_vld_d = hold_vld_q;
          end
        end
        ST_DRAIN: begin
          drain_first_d = 1'b0;
          if (drain_done_s) begin
            rr_d      = next_idx(gidx_q);
            grant_d   = '0;
            gap_cnt_d = cfg_gap_i;
          end else begin
            grant_d = grant_q;
          end
        end
        ST_GAP: begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
        default: begin
          grant_d    = '0;
          hold_vld_d = 1'b0;
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign tx_data_o  = hold_data_q;
  assign tx_valid_o = hold_vld_q;
  assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_udma_uart_tx_arb.sv
// Randomized bench for udma_uart_tx_arb: packet-level round-robin model plus a small serializer model.
module tb_udma_uart_tx_arb;

  localparam int N  = 4;
  localparam int GW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_en;
  logic [GW-1:0]   cfg_gap;
  logic [N-1:0]    req_valid;
  logic [N*8-1:0]  req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready_o;
  logic [7:0]      tx_data_o;
  logic            tx_valid_o;
  logic            tx_ready;
  logic            tx_busy;
  logic [N-1:0]    grant_o;
  logic            busy_o;

  always #5 clk = ~clk;

  udma_uart_tx_arb #(.NUM_REQ(N), .GAP_W(GW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_en_i    (cfg_en),
    .cfg_gap_i   (cfg_gap),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_last_i  (req_last),
    .req_ready_o (req_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready),
    .tx_busy_i   (tx_busy),
    .grant_o     (grant_o),
    .busy_o      (busy_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Requester byte queues {last, data}, expected serializer stream and packet owner order.
  logic [8:0] rq [N][$];
  logic [8:0] exp_items [$];
  int         exp_owner [$];
  int         mptr = 0;

  // Serializer model: one dead cycle after accept, then busy for a few cycles.
  logic ser_pend = 1'b0;
  int   ser_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic random_fill();
    int np;
    int len;
    for (int r = 0; r < N; r++) begin
      np = (r == N - 1) ? $urandom_range(1, 2) : $urandom_range(0, 2);
      for (int p = 0; p < np; p++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) add_byte(r, 8'($urandom), (b == len - 1));
      end
    end
  endtask

  // Round-robin over whole packets: every requester with data is valid at each arbitration.
  task automatic build_expected();
    logic [8:0] cp [N][$];
    logic [8:0] item;
    int         r;
    bit         found;
    for (int i = 0; i < N; i++) cp[i] = rq[i];
    for (int guard = 0; guard < 1000; guard++) begin
      found = 1'b0;
      r = 0;
      for (int k = N - 1; k >= 0; k--) begin
        if (cp[(mptr + k) % N].size() > 0) begin
          found = 1'b1;
          r = (mptr + k) % N;
        end
      end
      if (!found) break;
      exp_owner.push_back(r);
      do begin
        item = cp[r].pop_front();
        exp_items.push_back(item);
      end while (!item[8]);
      mptr = (r + 1) % N;
    end
  endtask

  task automatic run_phase(input int gap);
    logic [N-1:0] prev_grant;
    logic [N-1:0] xr;
    logic [N-1:0] midpkt;
    logic [N-1:0] exp_rdy;
    logic [8:0]   item;
    int           cur_owner;
    int           zb;
    bit           seen_fall;
    bit           pkt_wait;
    bit           pkt_done;
    bit           accepted;
    bit           acc_last;
    bit           done;
    cfg_gap    = GW'(gap);
    build_expected();
    prev_grant = '0;
    midpkt     = '0;
    cur_owner  = -1;
    zb         = 0;
    seen_fall  = 1'b0;
    pkt_wait   = 1'b0;
    pkt_done   = 1'b0;
    done       = 1'b0;
    for (int cyc = 0; cyc < 6000 && !done; cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (rq[r].size() > 0) begin
          item = rq[r][0];
          req_valid[r] = !(midpkt[r] && ($urandom_range(0, 2) == 0));
          req_data[8*r +: 8] = item[7:0];
          req_last[r] = item[8];
        end else begin
          req_valid[r] = 1'b0;
          req_data[8*r +: 8] = 8'h00;
          req_last[r] = 1'b0;
        end
      end
      tx_ready = !ser_pend && (ser_cnt == 0);
      tx_busy  = (ser_cnt != 0);
      @(negedge clk);
      if (grant_o != '0 && prev_grant == '0) begin
        if (exp_owner.size() == 0) begin
          chk("grant_extra", grant_o, 32'h0);
        end else begin
          cur_owner = exp_owner.pop_front();
          chk("grant_order", grant_o, 32'h1 << cur_owner);
          if (seen_fall) chk("gap_len", zb, gap);
        end
        pkt_done = 1'b0;
      end
      if (grant_o == '0 && prev_grant != '0) begin
        chk("grant_hold", pkt_done, 32'h1);
        seen_fall = 1'b1;
        zb = 0;
        cur_owner = -1;
      end
      if (grant_o == '0 && busy_o) zb++;
      exp_rdy = (cur_owner >= 0) ? N'(1 << cur_owner) : '0;
      chk("ready_owner", req_ready_o & ~exp_rdy, 32'h0);
      xr = req_valid & req_ready_o;
      accepted = tx_valid_o && tx_ready;
      acc_last = 1'b0;
      if (accepted) begin
        if (exp_items.size() == 0) begin
          chk("tx_extra", tx_data_o, 32'h0);
        end else begin
          item = exp_items.pop_front();
          chk("tx_byte", tx_data_o, item[7:0]);
          acc_last = item[8];
        end
      end
      prev_grant = grant_o;
      done = (exp_items.size() == 0) && (exp_owner.size() == 0) && !busy_o &&
             !accepted && !ser_pend && (ser_cnt == 0) && (grant_o == '0);
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (xr[r]) begin
          item = rq[r].pop_front();
          midpkt[r] = !item[8];
        end
      end
      if (accepted) begin
        ser_pend = 1'b1;
        if (acc_last) pkt_wait = 1'b1;
      end else if (ser_pend) begin
        ser_pend = 1'b0;
        ser_cnt  = $urandom_range(2, 5);
      end else if (ser_cnt > 0) begin
        ser_cnt--;
        if (ser_cnt == 0 && pkt_wait) begin
          pkt_done = 1'b1;
          pkt_wait = 1'b0;
        end
      end
    end
    chk("phase_done", done, 32'h1);
    if (seen_fall) chk("gap_tail", zb, gap);
    for (int r = 0; r < N; r++) rq[r].delete();
    exp_items.delete();
    exp_owner.delete();
    req_valid = '0;
  endtask

  initial begin
    bit got;
    rst       = 1'b1;
    cfg_en    = 1'b1;
    cfg_gap   = '0;
    req_valid = '1;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b0;
    tx_busy   = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_grant", grant_o, 32'h0);
      chk("reset_ready", req_ready_o, 32'h0);
      chk("reset_txvalid", tx_valid_o, 32'h0);
      chk("reset_txdata", tx_data_o, 32'h0);
      chk("reset_busy", busy_o, 32'h0);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    rst = 1'b0;

    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h22, 1'b0);
    add_byte(0, 8'h33, 1'b1);
    run_phase(0);

    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 3; r++) add_byte(r, 8'($urandom), 1'b1);
    run_phase(0);

    random_fill();
    run_phase(5);
    random_fill();
    run_phase(0);
    random_fill();
    run_phase(2);

    // Req2 alone leaves the pointer at 3 for the enable test below.
    add_byte(2, 8'h7E, 1'b1);
    run_phase(0);

    req_valid = 4'b0010;
    req_data  = {8'h00, 8'h00, 8'hA5, 8'h00};
    req_last  = '0;
    tx_ready  = 1'b0;
    tx_busy   = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (tx_valid_o) begin
        got = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    chk("en_hold_seen", got, 32'h1);
    chk("en_grant_before", grant_o, 32'h2);
    chk("en_data_before", tx_data_o, 32'hA5);
    @(posedge clk);
    #1;
    cfg_en    = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("en_off_txvalid", tx_valid_o, 32'h0);
    chk("en_off_grant", grant_o, 32'h0);
    chk("en_off_busy", busy_o, 32'h0);
    cfg_en    = 1'b1;
    req_valid = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    chk("en_resume_grant", grant_o, 32'h8);
    chk("en_resume_busy", busy_o, 32'h1);
    cfg_en    = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    chk("final_idle", busy_o, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
